hdlc_rx_channel: RTL and testbench

Receive-side bit-level front end of the HDLC controller, sitting between the serial Rx pin and the Rx buffer/FCS logic. It detects flags (0x7E) and aborts (seven or more consecutive 1s), removes inserted zeros, and assembles LSB-first octets. It produces per-byte strobes and frame-boundary events that feed the Rx buffer and register block (Rx_NewByte, Rx_Data, Rx_FlagDetect, Rx_EoF, Rx_AbortSignal, Rx_FrameError, Rx_Overflow, Rx_FrameSize, Rx_ValidFrame).

---
 rtl/hdlc_pkg.sv | 17 +
 rtl/hdlc_rx_destuff.sv | 75 +++++++
 rtl/hdlc_rx_channel.sv | 153 +++++++++++++++
 tb/tb_hdlc_rx_channel.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/hdlc_pkg.sv
// Shared constants and types for the HDLC receive path.
package hdlc_pkg;

    localparam logic [7:0] HDLC_FLAG = 8'h7E;

    // Run lengths of consecutive 1s that change how the following bit is classified.
    localparam int ONES_STUFF = 5;
    localparam int ONES_FLAG  = 6;
    localparam int ONES_ABORT = 7;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        OPEN    = 2'd1,
        INFRAME = 2'd2
    } rx_state_t;

endpackage

// File: rtl/hdlc_rx_destuff.sv
// Ones counting, stuffed-zero removal, flag/abort detection and the 7-bit hold pipeline.
module hdlc_rx_destuff
    import hdlc_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic rx,
    input  logic en,
    output logic bit_valid,
    output logic bit_value,
    output logic flag,
    output logic abort
);

    logic [2:0] ones_reg, ones_next;
    logic [6:0] hold_reg, hold_next;
    logic [2:0] occ_reg, occ_next;
    logic       push;

    // The hold pipeline delays data by seven bits so a flag's leading 0 and six 1s
    // can be thrown away before they ever reach the byte assembler.
    assign bit_value = hold_reg[6];

    always_comb begin
        ones_next = ones_reg;
        hold_next = hold_reg;
        occ_next  = occ_reg;
        push      = 1'b0;
        flag      = 1'b0;
        abort     = 1'b0;
        bit_valid = 1'b0;
        if (en) begin
            if (rx) begin
                push = 1'b1;
                if (ones_reg != 3'(ONES_ABORT)) begin
                    ones_next = ones_reg + 3'd1;
                end
                if (ones_reg == 3'(ONES_ABORT - 1)) begin
                    abort = 1'b1;
                end
            end else begin
                ones_next = 3'd0;
                if (ones_reg == 3'(ONES_FLAG)) begin
                    flag = 1'b1;
                end else if (ones_reg != 3'(ONES_STUFF)) begin
                    push = 1'b1;
                end
            end
            if (push) begin
                hold_next = {hold_reg[5:0], rx};
                bit_valid = (occ_reg == 3'd7);
                if (occ_reg != 3'd7) begin
                    occ_next = occ_reg + 3'd1;
                end
            end
            // The abort bit itself still pops the last genuine data bit before flushing.
            if (flag || abort) begin
                occ_next = 3'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ones_reg <= 3'd0;
            hold_reg <= 7'd0;
            occ_reg  <= 3'd0;
        end else begin
            ones_reg <= ones_next;
            hold_reg <= hold_next;
            occ_reg  <= occ_next;
        end
    end

endmodule

// File: rtl/hdlc_rx_channel.sv
// HDLC receive front end: frame state machine, LSB-first byte assembly and frame events.
module hdlc_rx_channel
    import hdlc_pkg::*;
#(
    parameter int MAX_BYTES = 128
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Rx,
    input  logic       RxEN,
    output logic [7:0] Rx_Data,
    output logic       Rx_NewByte,
    output logic       Rx_FlagDetect,
    output logic       Rx_ValidFrame,
    output logic       Rx_EoF,
    output logic       Rx_AbortSignal,
    output logic       Rx_FrameError,
    output logic       Rx_Overflow,
    output logic [7:0] Rx_FrameSize
);

    logic bit_valid, bit_value, flag, abort;

    hdlc_rx_destuff u_destuff (
        .clk       (Clk),
        .rst       (Rst),
        .rx        (Rx),
        .en        (RxEN),
        .bit_valid (bit_valid),
        .bit_value (bit_value),
        .flag      (flag),
        .abort     (abort)
    );

    rx_state_t  state_reg, state_next;
    logic [2:0] bit_cnt_reg, bit_cnt_next;
    logic [7:0] shift_reg, shift_next;
    logic [7:0] data_reg, data_next;
    logic [7:0] size_reg, size_next;
    logic       ovf_done_reg, ovf_done_next;
    logic       valid_reg, valid_next;
    logic       new_byte_reg, new_byte_next;
    logic       flag_det_reg, flag_det_next;
    logic       eof_reg, eof_next;
    logic       abort_sig_reg, abort_sig_next;
    logic       ferr_reg, ferr_next;
    logic       ovf_reg, ovf_next;
    logic [7:0] shifted;

    assign shifted = {bit_value, shift_reg[7:1]};

    always_comb begin
        state_next     = state_reg;
        bit_cnt_next   = bit_cnt_reg;
        shift_next     = shift_reg;
        data_next      = data_reg;
        size_next      = size_reg;
        ovf_done_next  = ovf_done_reg;
        valid_next     = valid_reg;
        new_byte_next  = 1'b0;
        flag_det_next  = 1'b0;
        eof_next       = 1'b0;
        abort_sig_next = 1'b0;
        ferr_next      = 1'b0;
        ovf_next       = 1'b0;

        // Data popped out of the hold pipeline; ignored while hunting for a flag.
        if (bit_valid && state_reg != HUNT) begin
            if (state_reg == OPEN) begin
                state_next    = INFRAME;
                valid_next    = 1'b1;
                size_next     = 8'd0;
                ovf_done_next = 1'b0;
            end
            shift_next   = shifted;
            bit_cnt_next = bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
                data_next     = shifted;
                new_byte_next = 1'b1;
                if (size_next == 8'(MAX_BYTES) && !ovf_done_next) begin
                    ovf_next      = 1'b1;
                    ovf_done_next = 1'b1;
                end
                if (size_next != 8'hFF) begin
                    size_next = size_next + 8'd1;
                end
            end
        end

        if (flag) begin
            flag_det_next = 1'b1;
            bit_cnt_next  = 3'd0;
            if (state_reg == INFRAME) begin
                eof_next   = 1'b1;
                ferr_next  = (bit_cnt_reg != 3'd0);
                valid_next = 1'b0;
            end
            state_next = OPEN;
        end

        if (abort) begin
            if (state_next == INFRAME) begin
                abort_sig_next = 1'b1;
            end
            state_next   = HUNT;
            valid_next   = 1'b0;
            bit_cnt_next = 3'd0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_reg     <= HUNT;
            bit_cnt_reg   <= 3'd0;
            shift_reg     <= 8'd0;
            data_reg      <= 8'd0;
            size_reg      <= 8'd0;
            ovf_done_reg  <= 1'b0;
            valid_reg     <= 1'b0;
            new_byte_reg  <= 1'b0;
            flag_det_reg  <= 1'b0;
            eof_reg       <= 1'b0;
            abort_sig_reg <= 1'b0;
            ferr_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            bit_cnt_reg   <= bit_cnt_next;
            shift_reg     <= shift_next;
            data_reg      <= data_next;
            size_reg      <= size_next;
            ovf_done_reg  <= ovf_done_next;
            valid_reg     <= valid_next;
            new_byte_reg  <= new_byte_next;
            flag_det_reg  <= flag_det_next;
            eof_reg       <= eof_next;
            abort_sig_reg <= abort_sig_next;
            ferr_reg      <= ferr_next;
            ovf_reg       <= ovf_next;
        end
    end

    assign Rx_Data        = data_reg;
    assign Rx_NewByte     = new_byte_reg;
    assign Rx_FlagDetect  = flag_det_reg;
    assign Rx_ValidFrame  = valid_reg;
    assign Rx_EoF         = eof_reg;
    assign Rx_AbortSignal = abort_sig_reg;
    assign Rx_FrameError  = ferr_reg;
    assign Rx_Overflow    = ovf_reg;
    assign Rx_FrameSize   = size_reg;

endmodule

// File: tb/tb_hdlc_rx_channel.sv
// Directed bench for hdlc_rx_channel: flags, stuffing, aborts, frame errors, overflow, reset.
module tb_hdlc_rx_channel;

    logic       clk = 1'b0;
    logic       rst, rx, rxen;
    logic [7:0] rx_data, frame_size;
    logic       new_byte, flag_det, valid_frame, eof, abort_sig, frame_err, overflow;

    always #5 clk = ~clk;

    hdlc_rx_channel #(.MAX_BYTES(4)) dut (
        .Clk            (clk),
        .Rst            (rst),
        .Rx             (rx),
        .RxEN           (rxen),
        .Rx_Data        (rx_data),
        .Rx_NewByte     (new_byte),
        .Rx_FlagDetect  (flag_det),
        .Rx_ValidFrame  (valid_frame),
        .Rx_EoF         (eof),
        .Rx_AbortSignal (abort_sig),
        .Rx_FrameError  (frame_err),
        .Rx_Overflow    (overflow),
        .Rx_FrameSize   (frame_size)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Event counters, written only by the monitor.
    int         c_byte = 0, c_flag = 0, c_eof = 0, c_abort = 0, c_ferr = 0, c_ferr_eof = 0;
    int         c_ovf = 0, c_ovf_byte = 0, ovf_idx = 0;
    logic [7:0] byte_log [0:63];

    int b_byte, b_flag, b_eof, b_abort, b_ferr, b_ferr_eof, b_ovf, b_ovf_byte;
    int tb_ones = 0;
    bit use_gaps = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (new_byte) begin
                byte_log[c_byte] = rx_data;
                c_byte = c_byte + 1;
                $display("[TB] byte %0d received: 0x%02h size=%0d", c_byte, rx_data, frame_size);
            end
            if (flag_det) c_flag = c_flag + 1;
            if (eof) c_eof = c_eof + 1;
            if (abort_sig) c_abort = c_abort + 1;
            if (frame_err) c_ferr = c_ferr + 1;
            if (frame_err && eof) c_ferr_eof = c_ferr_eof + 1;
            if (overflow) begin
                c_ovf = c_ovf + 1;
                ovf_idx = c_byte;
            end
            if (overflow && new_byte) c_ovf_byte = c_ovf_byte + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_byte = c_byte; b_flag = c_flag; b_eof = c_eof; b_abort = c_abort;
        b_ferr = c_ferr; b_ferr_eof = c_ferr_eof; b_ovf = c_ovf; b_ovf_byte = c_ovf_byte;
    endtask

    task automatic idle(input int n);
        rxen = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        if (use_gaps) begin
            repeat ($urandom_range(0, 2)) begin
                rxen = 1'b0;
                rx   = 1'($urandom);
                @(posedge clk);
                #1;
            end
        end
        rx   = b;
        rxen = 1'b1;
        @(posedge clk);
        #1;
        tb_ones = b ? tb_ones + 1 : 0;
    endtask

    task automatic send_flag();
        logic [7:0] f;
        f = hdlc_pkg::HDLC_FLAG;
        for (int i = 0; i < 8; i++) send_bit(f[i]);
        tb_ones = 0;
    endtask

    // Sends a byte LSB-first, inserting a 0 after every run of five 1s.
    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            send_bit(v[i]);
            if (tb_ones == 5) send_bit(1'b0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " data"}, 32'(rx_data), 32'h0);
        chk({tag, " newbyte"}, 32'(new_byte), 32'h0);
        chk({tag, " flagdet"}, 32'(flag_det), 32'h0);
        chk({tag, " valid"}, 32'(valid_frame), 32'h0);
        chk({tag, " eof"}, 32'(eof), 32'h0);
        chk({tag, " abort"}, 32'(abort_sig), 32'h0);
        chk({tag, " ferr"}, 32'(frame_err), 32'h0);
        chk({tag, " ovf"}, 32'(overflow), 32'h0);
        chk({tag, " size"}, 32'(frame_size), 32'h0);
    endtask

    initial begin
        rst = 1'b1; rx = 1'b0; rxen = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_all_zero("reset");

        // Idle all-ones line while hunting: nothing at all.
        snap();
        for (int i = 0; i < 20; i++) send_bit(1'b1);
        idle(2);
        chk("idle1 flags", c_flag - b_flag, 0);
        chk("idle1 abort", c_abort - b_abort, 0);
        chk("idle1 bytes", c_byte - b_byte, 0);

        // Test 1: flag, A5, 3C, flag.
        snap();
        send_flag(); send_byte(8'hA5); send_byte(8'h3C); send_flag();
        idle(2);
        chk("t1 bytes", c_byte - b_byte, 2);
        chk("t1 byte0", 32'(byte_log[b_byte]), 32'hA5);
        chk("t1 byte1", 32'(byte_log[b_byte + 1]), 32'h3C);
        chk("t1 eof", c_eof - b_eof, 1);
        chk("t1 ferr", c_ferr - b_ferr, 0);
        chk("t1 flags", c_flag - b_flag, 2);
        chk("t1 size", 32'(frame_size), 32'd2);
        chk("t1 valid", 32'(valid_frame), 32'd0);

        // Test 2: bytes that need stuffing.
        snap();
        send_flag(); send_byte(8'hFF); send_byte(8'h7C); send_flag();
        idle(2);
        chk("t2 bytes", c_byte - b_byte, 2);
        chk("t2 byte0", 32'(byte_log[b_byte]), 32'hFF);
        chk("t2 byte1", 32'(byte_log[b_byte + 1]), 32'h7C);
        chk("t2 flags", c_flag - b_flag, 2);
        chk("t2 eof", c_eof - b_eof, 1);

        // Test 3: abort inside a frame, then recovery with a fresh frame.
        snap();
        send_flag(); send_byte(8'h12);
        chk("t3 valid mid", 32'(valid_frame), 32'd1);
        for (int i = 0; i < 8; i++) send_bit(1'b1);
        idle(2);
        chk("t3 bytes", c_byte - b_byte, 1);
        chk("t3 byte0", 32'(byte_log[b_byte]), 32'h12);
        chk("t3 abort", c_abort - b_abort, 1);
        chk("t3 eof", c_eof - b_eof, 0);
        chk("t3 valid end", 32'(valid_frame), 32'd0);
        snap();
        send_flag(); send_byte(8'h5A); send_flag();
        idle(2);
        chk("t3 recover byte", 32'(byte_log[b_byte]), 32'h5A);
        chk("t3 recover eof", c_eof - b_eof, 1);
        chk("t3 recover abort", c_abort - b_abort, 0);

        // Test 4: 12 data bits -> frame error.
        snap();
        send_flag(); send_byte(8'hC3);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        send_flag();
        idle(2);
        chk("t4 bytes", c_byte - b_byte, 1);
        chk("t4 byte0", 32'(byte_log[b_byte]), 32'hC3);
        chk("t4 eof+ferr", c_ferr_eof - b_ferr_eof, 1);
        chk("t4 ferr", c_ferr - b_ferr, 1);
        chk("t4 size", 32'(frame_size), 32'd1);

        // Test 5: overflow with MAX_BYTES=4.
        snap();
        send_flag();
        for (int i = 1; i <= 5; i++) send_byte(8'(i));
        send_flag();
        idle(2);
        chk("t5 bytes", c_byte - b_byte, 5);
        chk("t5 byte4", 32'(byte_log[b_byte + 4]), 32'h05);
        chk("t5 ovf", c_ovf - b_ovf, 1);
        chk("t5 ovf with byte", c_ovf_byte - b_ovf_byte, 1);
        chk("t5 ovf index", ovf_idx, b_byte + 5);
        chk("t5 size", 32'(frame_size), 32'd5);
        chk("t5 eof", c_eof - b_eof, 1);

        // Test 6: shared flag, random RxEN gaps, reset mid third frame.
        snap();
        use_gaps = 1;
        send_flag(); send_byte(8'h11); send_byte(8'h22);
        send_flag(); send_byte(8'h33);
        send_flag(); send_byte(8'h44);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        use_gaps = 0;
        idle(2);
        chk("t6 bytes", c_byte - b_byte, 3);
        chk("t6 byte0", 32'(byte_log[b_byte]), 32'h11);
        chk("t6 byte1", 32'(byte_log[b_byte + 1]), 32'h22);
        chk("t6 byte2", 32'(byte_log[b_byte + 2]), 32'h33);
        chk("t6 eof", c_eof - b_eof, 2);
        chk("t6 valid mid", 32'(valid_frame), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all_zero("t6 after rst");
        // Still hunting after reset: data before a flag must not be framed.
        snap();
        send_byte(8'h55); send_byte(8'h55); send_flag();
        idle(2);
        chk("t6 hunt bytes", c_byte - b_byte, 0);
        chk("t6 hunt eof", c_eof - b_eof, 0);
        chk("t6 hunt abort", c_abort - b_abort, 0);
        chk("t6 hunt flags", c_flag - b_flag, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
